// File: rtl/sdf_frame_sequencer.sv
// sdf_frame_sequencer: keeps the SDF FFT input strobe gap-free and N-aligned, flushes drained frames and tags natural-order output bins.
module sdf_frame_sequencer #(
  parameter int LOG2N = 3,
  parameter int DW    = 16,
  parameter int FLWD  = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DW-1:0]    s_re,
  input  logic [DW-1:0]    s_im,
  output logic             pipe_en,
  output logic [DW-1:0]    pipe_re,
  output logic [DW-1:0]    pipe_im,
  input  logic             pipe_do_en,
  input  logic [DW-1:0]    pipe_do_re,
  input  logic [DW-1:0]    pipe_do_im,
  output logic             m_valid,
  output logic [DW-1:0]    m_re,
  output logic [DW-1:0]    m_im,
  output logic             m_sof,
  output logic             m_eof,
  output logic [LOG2N-1:0] m_idx,
  output logic             busy,
  output logic             underrun,
  input  logic             err_clr
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state_q, state_d;
  logic [LOG2N-1:0] slot_q, slot_d, out_cnt_q, out_cnt_d, m_idx_q, m_idx_d, rev;
  logic [FLWD-1:0] inflight_q, inflight_d;
  logic pend_q, pend_d, pipe_en_q, pipe_en_d, underrun_q, underrun_d;
  logic m_valid_q, m_valid_d, m_sof_q, m_sof_d, m_eof_q, m_eof_d;
  logic [DW-1:0] hold_re_q, hold_re_d, hold_im_q, hold_im_d;
  logic [DW-1:0] pipe_re_q, pipe_re_d, pipe_im_q, pipe_im_d;
  logic [DW-1:0] m_re_q, m_re_d, m_im_q, m_im_d;
  logic hs, ur_set, inc, ov, dec;
  // A sample taken in the last flush cycle waits one cycle in hold_* so it lands in slot 0.
  always_comb begin
    s_ready = (state_q != FLUSH) || (&slot_q);
    hs = s_valid && s_ready;
    hold_re_d = hs ? s_re : hold_re_q;
    hold_im_d = hs ? s_im : hold_im_q;
    pipe_en_d = (state_q != IDLE) || hs;
    pipe_re_d = (state_q == FLUSH) ? '0 : pend_q ? hold_re_q : hs ? s_re : '0;
    pipe_im_d = (state_q == FLUSH) ? '0 : pend_q ? hold_im_q : hs ? s_im : '0;
    ur_set = (state_q == RUN) && !pend_q && !hs && (|slot_q);
    state_d = state_q;
    pend_d = pend_q;
    if (state_q == IDLE) begin
      state_d = hs ? RUN : IDLE;
    end else if (state_q == RUN) begin
      pend_d = pend_q && hs;
      state_d = (!pend_q && !hs && ~|slot_q) ? FLUSH : RUN;
    end else if (&slot_q) begin
      pend_d = hs;
      state_d = hs ? RUN : IDLE;
    end
    slot_d = pipe_en_d ? slot_q + 1'b1 : '0;
    underrun_d = ur_set || (underrun_q && !err_clr);
    inc = (state_q == RUN) && (&slot_q);
    ov = pipe_do_en && (|inflight_q);
    dec = ov && (&out_cnt_q);
    inflight_d = (inc && !dec && !(&inflight_q)) ? inflight_q + 1'b1 :
                 (dec && !inc) ? inflight_q - 1'b1 : inflight_q;
    out_cnt_d = ov ? out_cnt_q + 1'b1 : out_cnt_q;
    rev = '0;
    for (int i = 0; i < LOG2N; i++) rev[i] = out_cnt_q[LOG2N-1-i];
    m_valid_d = ov;
    m_re_d = ov ? pipe_do_re : '0;
    m_im_d = ov ? pipe_do_im : '0;
    m_sof_d = ov && (~|out_cnt_q);
    m_eof_d = dec;
    m_idx_d = ov ? rev : '0;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      slot_q <= '0;
      pend_q <= 1'b0;
      hold_re_q <= '0;
      hold_im_q <= '0;
      pipe_en_q <= 1'b0;
      pipe_re_q <= '0;
      pipe_im_q <= '0;
      underrun_q <= 1'b0;
      inflight_q <= '0;
      out_cnt_q <= '0;
      m_valid_q <= 1'b0;
      m_re_q <= '0;
      m_im_q <= '0;
      m_sof_q <= 1'b0;
      m_eof_q <= 1'b0;
      m_idx_q <= '0;
    end else begin
      state_q <= state_d;
      slot_q <= slot_d;
      pend_q <= pend_d;
      hold_re_q <= hold_re_d;
      hold_im_q <= hold_im_d;
      pipe_en_q <= pipe_en_d;
      pipe_re_q <= pipe_re_d;
      pipe_im_q <= pipe_im_d;
      underrun_q <= underrun_d;
      inflight_q <= inflight_d;
      out_cnt_q <= out_cnt_d;
      m_valid_q <= m_valid_d;
      m_re_q <= m_re_d;
      m_im_q <= m_im_d;
      m_sof_q <= m_sof_d;
      m_eof_q <= m_eof_d;
      m_idx_q <= m_idx_d;
    end
  end
  assign pipe_en = pipe_en_q;
  assign pipe_re = pipe_re_q;
  assign pipe_im = pipe_im_q;
  assign m_valid = m_valid_q;
  assign m_re = m_re_q;
  assign m_im = m_im_q;
  assign m_sof = m_sof_q;
  assign m_eof = m_eof_q;
  assign m_idx = m_idx_q;
  assign underrun = underrun_q;
  assign busy = (state_q != IDLE) || (|inflight_q);
endmodule

// File: tb/tb_sdf_frame_sequencer.sv
// tb_sdf_frame_sequencer: random and directed streams checked against a queue-based frame model.
module tb_sdf_frame_sequencer;
  localparam int LOG2N = 3;
  localparam int N = 8;
  localparam int DW = 16;
  localparam int D = 5;
  logic clk = 1'b0, rstn = 1'b0;
  logic s_valid = 1'b0, s_ready, err_clr = 1'b0;
  logic [DW-1:0] s_re = '0, s_im = '0;
  logic pipe_en, pipe_do_en = 1'b0;
  logic [DW-1:0] pipe_re, pipe_im, pipe_do_re = '0, pipe_do_im = '0;
  logic m_valid, m_sof, m_eof, busy, underrun;
  logic [DW-1:0] m_re, m_im;
  logic [LOG2N-1:0] m_idx;
  sdf_frame_sequencer #(.LOG2N(LOG2N), .DW(DW), .FLWD(3)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
    .pipe_en(pipe_en), .pipe_re(pipe_re), .pipe_im(pipe_im),
    .pipe_do_en(pipe_do_en), .pipe_do_re(pipe_do_re), .pipe_do_im(pipe_do_im),
    .m_valid(m_valid), .m_re(m_re), .m_im(m_im), .m_sof(m_sof), .m_eof(m_eof), .m_idx(m_idx),
    .busy(busy), .underrun(underrun), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  // Model: mode 0 idle, 1 streaming, 2 flushing; pq holds samples accepted but not yet issued.
  int md = 0, sl = 0, infl = 0, ocnt = 0, peak = 0;
  logic [31:0] pq[$];
  logic e_en = 0, e_ur = 0, e_mv = 0, e_sof = 0, e_eof = 0, last_acc = 0;
  logic [DW-1:0] e_re = 0, e_im = 0, e_mre = 0, e_mim = 0;
  logic [LOG2N-1:0] e_idx = 0;
  logic dl_en[D];
  logic [DW-1:0] dl_re[D], dl_im[D];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask
  function automatic logic [LOG2N-1:0] bitrev(input int v);
    logic [LOG2N-1:0] r = '0;
    for (int i = 0; i < LOG2N; i++) if ((v >> i) & 1) r[LOG2N-1-i] = 1'b1;
    return r;
  endfunction
  task automatic model_reset();
    md = 0; sl = 0; infl = 0; ocnt = 0; pq.delete();
    e_en = 0; e_re = 0; e_im = 0; e_ur = 0; e_mv = 0; e_sof = 0; e_eof = 0; e_idx = 0;
    last_acc = 0;
    for (int i = 0; i < D; i++) begin dl_en[i] = 0; dl_re[i] = 0; dl_im[i] = 0; end
  endtask
  task automatic step(input bit want, input bit clr);
    bit rdy, hs, inc, dec, ov;
    logic [31:0] d;
    @(negedge clk);
    rdy = (md != 2) || (sl == N-1);
    chk("s_ready", s_ready, rdy);
    chk("pipe_en", pipe_en, e_en);
    if (e_en) begin chk("pipe_re", pipe_re, e_re); chk("pipe_im", pipe_im, e_im); end
    chk("m_valid", m_valid, e_mv);
    chk("m_sof", m_sof, e_sof);
    chk("m_eof", m_eof, e_eof);
    if (e_mv) begin chk("m_re", m_re, e_mre); chk("m_im", m_im, e_mim); chk("m_idx", m_idx, e_idx); end
    chk("busy", busy, md != 0 || infl != 0);
    chk("underrun", underrun, e_ur);
    if (!(s_valid && !last_acc)) begin
      s_valid = want; s_re = DW'($urandom); s_im = DW'($urandom);
    end
    err_clr = clr;
    for (int i = D-1; i > 0; i--) begin dl_en[i] = dl_en[i-1]; dl_re[i] = dl_re[i-1]; dl_im[i] = dl_im[i-1]; end
    dl_en[0] = pipe_en; dl_re[0] = pipe_re; dl_im[0] = pipe_im;
    pipe_do_en = dl_en[D-1]; pipe_do_re = dl_re[D-1]; pipe_do_im = dl_im[D-1];
    hs = s_valid && rdy;
    inc = 0;
    e_en = 0; e_re = 0; e_im = 0;
    if (md == 0) begin
      if (hs) begin e_en = 1; e_re = s_re; e_im = s_im; md = 1; end
    end else if (md == 1) begin
      e_en = 1;
      inc = (sl == N-1);
      if (pq.size() > 0) begin
        d = pq.pop_front(); e_re = d[31:16]; e_im = d[15:0];
        if (hs) pq.push_back({s_re, s_im});
      end else if (hs) begin
        e_re = s_re; e_im = s_im;
      end else if (sl != 0) e_ur = 1;
      else md = 2;
    end else begin
      e_en = 1;
      if (sl == N-1) begin
        if (hs) begin pq.push_back({s_re, s_im}); md = 1; end
        else md = 0;
      end
    end
    if (!(inc == 0 && md == 1 && e_en && !hs && pq.size() == 0 && sl != 0) && clr) e_ur = 0;
    sl = e_en ? (sl + 1) % N : 0;
    ov = pipe_do_en && infl > 0;
    dec = ov && ocnt == N-1;
    e_mv = ov; e_sof = ov && ocnt == 0; e_eof = dec;
    if (ov) begin
      e_mre = pipe_do_re; e_mim = pipe_do_im; e_idx = bitrev(ocnt);
      ocnt = (ocnt + 1) % N;
    end
    infl = infl + int'(inc) - int'(dec);
    if (infl > peak) peak = infl;
    last_acc = hs;
  endtask
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask
  task automatic async_reset();
    #2 rstn = 1'b0;
    s_valid = 0; err_clr = 0; pipe_do_en = 0;
    #1;
    chk("rst_pipe_en", pipe_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask
  initial begin
    bit ur_set_cycle;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_pipe_en", pipe_en, 0);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_s_ready", s_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_underrun", underrun, 0);
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) step(1, 0);
    idle_gap(40);
    for (int i = 0; i < 16; i++) step(1, 0);
    idle_gap(40);
    chk("peak_inflight_le2", peak <= 2, 1);
    for (int i = 0; i < 3; i++) step(1, 0);
    step(0, 0); step(0, 0);
    for (int i = 0; i < 3; i++) step(1, 0);
    idle_gap(20);
    chk("underrun_sticky", underrun, 1);
    step(0, 1);
    idle_gap(20);
    for (int i = 0; i < 8; i++) step(1, 0);
    step(0, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 16; i++) step(1, 0);
    idle_gap(40);
    for (int i = 0; i < 5; i++) step(1, 0);
    async_reset();
    for (int i = 0; i < 8; i++) step(1, 0);
    idle_gap(40);
    for (int b = 0; b < 25; b++) begin
      int p = (b % 3 == 0) ? 100 : (b % 3 == 1) ? 90 : 60;
      int len = $urandom_range(8, 40);
      for (int i = 0; i < len; i++) step($urandom_range(0, 99) < p, $urandom_range(0, 19) == 0);
      idle_gap($urandom_range(0, 30));
    end
    idle_gap(40);
    chk("final_idle_busy", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
